// File: rtl/uart_mmio_peripheral.sv
// rtl/uart_mmio_peripheral.sv - 8N1 UART device behind the core's MMIO data/status registers (option: UART_RX_FIFO_EN)
module uart_mmio_peripheral #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
`ifdef UART_RX_FIFO_EN
  ,
  parameter int RX_FIFO_DEPTH = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  input  logic       rx_re,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t      tx_state_q, tx_state_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           txd_q, txd_d;

  rx_state_t      rx_state_q, rx_state_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic [1:0]     rx_sync_q;
  logic           rxs;
  logic           rx_commit;

  assign rxs      = rx_sync_q[1];
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign uart_txd = txd_q;

  // TX state register; txd is registered so the pin never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // TX next state: each phase lasts one full bit period, data goes out LSB first
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_we) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX synchronizer and state register; sync flops idle high like the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rxd};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: half-bit start qualification, then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_commit  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxs) begin
            rx_commit  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (rxs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);

  logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (count_q == (AW+1)'(RX_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = rx_re && !fifo_empty;
  assign push       = rx_commit && (!fifo_full || pop);
  assign rx_data    = fifo_mem[rptr_q];
  assign rx_valid   = !fifo_empty;

  // RX FIFO: a pop frees a slot in the same cycle, so push+pop when full both succeed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr_q] <= rx_shift_q;
        wptr_q           <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (rx_commit && !push) rx_overrun <= 1'b1;
      else if (pop)           rx_overrun <= 1'b0;
    end
  end
`else
  // Single holding register: a new byte only replaces an unread one if it is being read now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_commit) begin
      if (!rx_valid || rx_re) begin
        rx_data  <= rx_shift_q;
        rx_valid <= 1'b1;
        if (rx_re) rx_overrun <= 1'b0;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_re && rx_valid) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// tb/tb_uart_mmio_peripheral.sv - scoreboard bench for uart_mmio_peripheral (10 clocks per bit)
module tb_uart_mmio_peripheral;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_we = 1'b0;
  logic       tx_busy;
  logic       rx_re = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  bit   tx_abort = 1'b0;
  logic rx_prev = 1'b0;
  logic tx_prev = 1'b1;

  uart_mmio_peripheral #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .rx_re(rx_re), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // rx monitor: each new byte presented on rx_valid is compared to the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && !rx_prev) begin
        if (exp_rx.size() == 0) check("rx_unexpected_byte", {24'h0, rx_data}, 32'h1ff);
        else                    check("rx_byte", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
      end
      rx_prev = rx_valid;
    end
  end

  // tx monitor: decode the serial line at mid-bit, checking start and stop levels too
  initial begin
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (tx_prev && !uart_txd) begin
        tx_abort = 1'b0;
        ok = 1'b1;
        repeat (CPB/2 - 1) @(negedge clk);
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (uart_txd !== 1'b1) ok = 1'b0;
        if (!tx_abort) begin
          if (exp_tx.size() == 0) check("tx_unexpected_frame", {23'h0, ok, b}, 32'h3ff);
          else                    check("tx_frame", {23'h0, ok, b}, {23'h0, 1'b1, exp_tx.pop_front()});
        end
      end
      tx_prev = uart_txd;
    end
  end

  task automatic tx_send(input logic [7:0] b, input int poke_at, output int busy_n);
    @(negedge clk);
    tx_data = b;
    tx_we   = 1'b1;
    @(negedge clk);
    tx_we  = 1'b0;
    busy_n = 0;
    while (tx_busy && busy_n < 300) begin
      busy_n++;
      if (busy_n == poke_at) begin
        tx_data = 8'hFF;
        tx_we   = 1'b1;
      end else begin
        tx_we = 1'b0;
      end
      @(negedge clk);
    end
    tx_we = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic rx_read(input string name);
    check({name, "_valid_before_re"}, {31'h0, rx_valid}, 32'h1);
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
    check({name, "_valid_after_re"}, {31'h0, rx_valid}, 32'h0);
  endtask

  initial begin
    int n;
    // reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst_tx_busy",    {31'h0, tx_busy},    32'h0);
    check("rst_uart_txd",   {31'h0, uart_txd},   32'h1);
    check("rst_rx_valid",   {31'h0, rx_valid},   32'h0);
    check("rst_rx_data",    {24'h0, rx_data},    32'h0);
    check("rst_rx_overrun", {31'h0, rx_overrun}, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // plain tx frame
    exp_tx.push_back(8'h55);
    tx_send(8'h55, 0, n);
    check("tx_busy_cycles", n, 100);
    repeat (20) @(negedge clk);

    // write while busy is ignored
    exp_tx.push_back(8'h55);
    tx_send(8'h55, 30, n);
    check("tx_busy_cycles_poked", n, 100);
    repeat (20) @(negedge clk);

    // plain rx frame
    exp_rx.push_back(8'hA3);
    rx_send(8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    rx_read("rx_a3");

    // overrun with holding register
    exp_rx.push_back(8'h11);
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    check("ovr_rx_data",    {24'h0, rx_data},    32'h11);
    check("ovr_rx_overrun", {31'h0, rx_overrun}, 32'h1);
    rx_read("ovr");
    check("ovr_cleared", {31'h0, rx_overrun}, 32'h0);

    // glitch on the line
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_valid", {31'h0, rx_valid}, 32'h0);

    // framing error, then a good frame
    rx_send(8'h5A, 1'b0);
    repeat (30) @(negedge clk);
    check("framing_no_valid", {31'h0, rx_valid}, 32'h0);
    exp_rx.push_back(8'h3C);
    rx_send(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    rx_read("rx_3c");

    // reset mid-operation with an unread byte held
    exp_rx.push_back(8'h5E);
    rx_send(8'h5E, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    tx_data = 8'h0F;
    tx_we   = 1'b1;
    @(negedge clk);
    tx_we = 1'b0;
    n = 1;
    while (n < 45) begin
      if (n == 10) uart_rxd = 1'b0;
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    tx_abort = 1'b1;
    #1;
    check("midrst_uart_txd", {31'h0, uart_txd}, 32'h1);
    check("midrst_tx_busy",  {31'h0, tx_busy},  32'h0);
    check("midrst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("midrst_rx_data",  {24'h0, rx_data},  32'h0);
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    rst = 1'b1;
    repeat (80) @(negedge clk);

    // clean tx and rx frames in parallel after release
    exp_tx.push_back(8'hC3);
    exp_rx.push_back(8'h96);
    fork
      begin
        int m;
        tx_send(8'hC3, 0, m);
        check("post_rst_busy_cycles", m, 100);
      end
      rx_send(8'h96, 1'b1);
    join
    repeat (20) @(negedge clk);
    rx_read("post_rst");

    check("exp_rx_drained", exp_rx.size(), 0);
    check("exp_tx_drained", exp_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
